// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the data-memory arbiter, its two requesters and the memory.
// The arbiter takes the slave view; the environment (requesters plus memory)
// takes the master view.
interface dmem_arbiter_if #(
    parameter int LANES = 4,
    parameter int DW    = 32,
    parameter int AW    = 32
);
    logic                  s_req;
    logic                  s_we;
    logic [AW-1:0]         s_addr;
    logic [DW-1:0]         s_wdata;
    logic                  s_ack;
    logic [DW-1:0]         s_rdata;

    logic                  v_req;
    logic                  v_we;
    logic [AW-1:0]         v_base;
    logic [AW-1:0]         v_stride;
    logic [LANES*DW-1:0]   v_wdata;
    logic                  v_ack;
    logic [LANES*DW-1:0]   v_rdata;

    logic                  busy;

    logic                  mem_we;
    logic [AW-1:0]         mem_addr;
    logic [DW-1:0]         mem_wdata;
    logic [DW-1:0]         mem_rdata;

    modport slave (
        input  s_req, s_we, s_addr, s_wdata,
        output s_ack, s_rdata,
        input  v_req, v_we, v_base, v_stride, v_wdata,
        output v_ack, v_rdata,
        output busy,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output s_req, s_we, s_addr, s_wdata,
        input  s_ack, s_rdata,
        output v_req, v_we, v_base, v_stride, v_wdata,
        input  v_ack, v_rdata,
        input  busy,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and sequencer in front of a single-port data memory.
// Scalar requests become one memory access; vector requests are unrolled into
// LANES strided word accesses with load data gathered into one wide response.
// All outputs are registered: the next-cycle memory command is computed
// together with the next state, so the memory sees clean flop outputs.
module dmem_arbiter #(
    parameter int LANES = 4,
    parameter int DW    = 32,
    parameter int AW    = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    dmem_arbiter_if.slave  bus
);
    localparam int IW = $clog2(LANES);
    localparam int VW = LANES * DW;

    typedef enum logic [1:0] {
        IDLE,
        SCALAR,
        VBURST,
        RESP
    } state_t;

    state_t          state_q,      state_d;
    logic [IW-1:0]   idx_q,        idx_d;
    logic [IW-1:0]   idx_next;
    logic            last_grant_q, last_grant_d;
    logic            we_q,         we_d;
    logic [AW-1:0]   stride_q,     stride_d;
    logic [VW-1:0]   v_wdata_q,    v_wdata_d;
    logic            mem_we_q,     mem_we_d;
    logic [AW-1:0]   mem_addr_q,   mem_addr_d;
    logic [DW-1:0]   mem_wdata_q,  mem_wdata_d;
    logic            s_ack_q,      s_ack_d;
    logic            v_ack_q,      v_ack_d;
    logic [DW-1:0]   s_rdata_q,    s_rdata_d;
    logic [VW-1:0]   v_rdata_q,    v_rdata_d;
    logic            busy_q,       busy_d;

    // Next-state and next-output logic; last_grant=1 means the vector side was
    // granted last, and the lane address advances by adding the stride.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        stride_d     = stride_q;
        v_wdata_d    = v_wdata_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;
        s_ack_d      = 1'b0;
        v_ack_d      = 1'b0;
        s_rdata_d    = s_rdata_q;
        v_rdata_d    = v_rdata_q;
        idx_next     = idx_q + IW'(1);

        case (state_q)
            IDLE: begin
                if (bus.s_req && (!bus.v_req || last_grant_q)) begin
                    state_d      = SCALAR;
                    last_grant_d = 1'b0;
                    we_d         = bus.s_we;
                    mem_we_d     = bus.s_we;
                    mem_addr_d   = bus.s_addr;
                    mem_wdata_d  = bus.s_wdata;
                end else if (bus.v_req) begin
                    state_d      = VBURST;
                    last_grant_d = 1'b1;
                    idx_d        = '0;
                    we_d         = bus.v_we;
                    stride_d     = bus.v_stride;
                    v_wdata_d    = bus.v_wdata;
                    mem_we_d     = bus.v_we;
                    mem_addr_d   = bus.v_base;
                    mem_wdata_d  = bus.v_wdata[DW-1:0];
                end
            end
            SCALAR: begin
                if (!we_q) begin
                    s_rdata_d = bus.mem_rdata;
                end
                s_ack_d = 1'b1;
                state_d = RESP;
            end
            VBURST: begin
                if (!we_q) begin
                    v_rdata_d[int'(idx_q)*DW +: DW] = bus.mem_rdata;
                end
                if (idx_q == IW'(LANES-1)) begin
                    state_d = RESP;
                    v_ack_d = 1'b1;
                    idx_d   = '0;
                end else begin
                    idx_d       = idx_next;
                    mem_we_d    = we_q;
                    mem_addr_d  = mem_addr_q + stride_q;
                    mem_wdata_d = v_wdata_q[int'(idx_next)*DW +: DW];
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset abandons any burst in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            stride_q     <= '0;
            v_wdata_q    <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            s_ack_q      <= 1'b0;
            v_ack_q      <= 1'b0;
            s_rdata_q    <= '0;
            v_rdata_q    <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            stride_q     <= stride_d;
            v_wdata_q    <= v_wdata_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            s_ack_q      <= s_ack_d;
            v_ack_q      <= v_ack_d;
            s_rdata_q    <= s_rdata_d;
            v_rdata_q    <= v_rdata_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.s_ack     = s_ack_q;
    assign bus.s_rdata   = s_rdata_q;
    assign bus.v_ack     = v_ack_q;
    assign bus.v_rdata   = v_rdata_q;
    assign bus.busy      = busy_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule
